// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and output defaults for the memory game control unit
package game_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_SETUP     = 4'd1,
        S_PREP      = 4'd2,
        S_PLAY_FPGA = 4'd3,
        S_PLAY_USER = 4'd4,
        S_CHECK     = 4'd5,
        S_NEXT      = 4'd6,
        S_ROUND_CHK = 4'd7,
        S_RESULT    = 4'd8
    } state_t;

    // Output vector order: {r1, r2, e1, e2, e3, e4, sel}
    localparam logic [6:0] OUT_DEFAULT = 7'b0000001;
    localparam logic [6:0] OUT_INIT    = 7'b1100001;
    localparam logic [6:0] OUT_SETUP   = 7'b0010001;
    localparam logic [6:0] OUT_PREP    = 7'b0100001;
    localparam logic [6:0] OUT_FPGA    = 7'b0000101;
    localparam logic [6:0] OUT_USER    = 7'b0001001;
    localparam logic [6:0] OUT_NEXT    = 7'b0000011;
    localparam logic [6:0] OUT_RESULT  = 7'b0000000;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on each rising edge of a synchronized level input
module edge_detect (
    input  logic clock_50,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // Remember the previous level so a held input yields a single pulse
    always_ff @(posedge clock_50) begin
        if (reset) din_q <= 1'b0;
        else       din_q <= din;
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/game_control.sv
// game_control: Moore FSM sequencing the memory game datapath
module game_control
    import game_pkg::*;
(
    input  logic       clock_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_fpga,
    input  logic       end_user,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       r1,
    output logic       r2,
    output logic       e1,
    output logic       e2,
    output logic       e3,
    output logic       e4,
    output logic       sel,
    output logic [3:0] state_o
);

    state_t     state_q, state_d;
    logic       enter_p;
    logic [6:0] outs;

    edge_detect u_enter_edge (
        .clock_50 (clock_50),
        .reset    (reset),
        .din      (enter),
        .pulse    (enter_p)
    );

    // State register; reset overrides any pending transition
    always_ff @(posedge clock_50) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // Next-state logic; unused codes fall back to S_INIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      state_d = S_SETUP;
            S_SETUP:     state_d = enter_p ? S_PREP : S_SETUP;
            S_PREP:      state_d = S_PLAY_FPGA;
            S_PLAY_FPGA: state_d = end_fpga ? S_PLAY_USER : S_PLAY_FPGA;
            S_PLAY_USER: state_d = end_time ? S_RESULT : (end_user ? S_CHECK : S_PLAY_USER);
            S_CHECK:     state_d = match ? S_NEXT : S_RESULT;
            S_NEXT:      state_d = S_ROUND_CHK;
            S_ROUND_CHK: state_d = win ? S_RESULT : S_PREP;
            S_RESULT:    state_d = enter_p ? S_INIT : S_RESULT;
            default:     state_d = S_INIT;
        endcase
    end

    // Moore output decode from the state register only
    always_comb begin
        outs = OUT_DEFAULT;
        case (state_q)
            S_INIT:      outs = OUT_INIT;
            S_SETUP:     outs = OUT_SETUP;
            S_PREP:      outs = OUT_PREP;
            S_PLAY_FPGA: outs = OUT_FPGA;
            S_PLAY_USER: outs = OUT_USER;
            S_NEXT:      outs = OUT_NEXT;
            S_RESULT:    outs = OUT_RESULT;
            default:     outs = OUT_DEFAULT;
        endcase
    end

    assign {r1, r2, e1, e2, e3, e4, sel} = outs;
    assign state_o = state_q;

endmodule

// File: tb/tb_game_control.sv
// tb_game_control: directed self-checking bench for game_control
module tb_game_control;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset, enter, end_fpga, end_user, end_time, win, match;
    logic       r1, r2, e1, e2, e3, e4, sel;
    logic [3:0] state_o;
    int         n_assert = 0;
    int         n_fail = 0;
    int         e4_cnt = 0;
    int         r2_cnt = 0;

    localparam logic [6:0] X_INIT   = 7'b1100001;
    localparam logic [6:0] X_SETUP  = 7'b0010001;
    localparam logic [6:0] X_PREP   = 7'b0100001;
    localparam logic [6:0] X_FPGA   = 7'b0000101;
    localparam logic [6:0] X_USER   = 7'b0001001;
    localparam logic [6:0] X_IDLE   = 7'b0000001;
    localparam logic [6:0] X_NEXT   = 7'b0000011;
    localparam logic [6:0] X_RESULT = 7'b0000000;

    game_control dut (
        .clock_50 (clk),
        .reset    (reset),
        .enter    (enter),
        .end_fpga (end_fpga),
        .end_user (end_user),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .r1       (r1),
        .r2       (r2),
        .e1       (e1),
        .e2       (e2),
        .e3       (e3),
        .e4       (e4),
        .sel      (sel),
        .state_o  (state_o)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        e4_cnt += int'(e4);
        r2_cnt += int'(r2);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic [6:0] o);
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_outs"}, 32'({r1, r2, e1, e2, e3, e4, sel}), 32'(o));
    endtask

    initial begin
        reset = 1; enter = 0; end_fpga = 0; end_user = 0; end_time = 0; win = 0; match = 0;
        repeat (3) step();
        chk_st("reset_hold", 4'd0, X_INIT);
        reset = 0;
        chk_st("release_c0", 4'd0, X_INIT);
        step(); chk_st("setup", 4'd1, X_SETUP);
        step(); chk_st("setup_wait", 4'd1, X_SETUP);
        enter = 1;
        step(); chk_st("prep", 4'd2, X_PREP);
        step(); chk_st("fpga", 4'd3, X_FPGA);
        r2_cnt = 0;
        repeat (97) step();
        check("held_enter_r2_cnt", 32'(r2_cnt), 32'd0);
        chk_st("held_enter_fpga", 4'd3, X_FPGA);
        enter = 0;
        e4_cnt = 0;
        end_fpga = 1; match = 1;
        step(); chk_st("user", 4'd4, X_USER);
        end_fpga = 0;
        step(); chk_st("user_wait", 4'd4, X_USER);
        end_user = 1;
        step(); chk_st("check", 4'd5, X_IDLE);
        end_user = 0;
        step(); chk_st("next", 4'd6, X_NEXT);
        step(); chk_st("round_chk", 4'd7, X_IDLE);
        step(); chk_st("loop_prep", 4'd2, X_PREP);
        check("round_e4_cnt", 32'(e4_cnt), 32'd1);
        step(); chk_st("fpga2", 4'd3, X_FPGA);
        end_fpga = 1;
        step(); chk_st("user2", 4'd4, X_USER);
        end_fpga = 0; end_time = 1; end_user = 1; e4_cnt = 0;
        step(); chk_st("timeout_result", 4'd8, X_RESULT);
        end_time = 0; end_user = 0;
        step(); chk_st("result_wait", 4'd8, X_RESULT);
        check("timeout_e4_cnt", 32'(e4_cnt), 32'd0);
        enter = 1;
        step(); chk_st("restart_init", 4'd0, X_INIT);
        step(); chk_st("restart_setup", 4'd1, X_SETUP);
        step(); chk_st("held_no_retrigger", 4'd1, X_SETUP);
        enter = 0;
        step();
        enter = 1;
        step(); chk_st("prep3", 4'd2, X_PREP);
        enter = 0;
        step(); chk_st("fpga3", 4'd3, X_FPGA);
        end_fpga = 1;
        step(); chk_st("user3", 4'd4, X_USER);
        end_fpga = 0; end_user = 1; match = 0;
        step(); chk_st("check3", 4'd5, X_IDLE);
        end_user = 0;
        step(); chk_st("mismatch_result", 4'd8, X_RESULT);
        enter = 1;
        step(); chk_st("mismatch_init", 4'd0, X_INIT);
        enter = 0;
        step(); chk_st("mismatch_setup", 4'd1, X_SETUP);
        enter = 1;
        step(); chk_st("prep4", 4'd2, X_PREP);
        enter = 0; end_fpga = 1;
        step(); chk_st("fpga4", 4'd3, X_FPGA);
        step(); chk_st("user4", 4'd4, X_USER);
        end_fpga = 0; end_user = 1; match = 1;
        step(); chk_st("check4", 4'd5, X_IDLE);
        end_user = 0;
        step(); chk_st("next4", 4'd6, X_NEXT);
        win = 1;
        step(); chk_st("round_chk4", 4'd7, X_IDLE);
        step(); chk_st("win_result", 4'd8, X_RESULT);
        win = 0; enter = 1;
        step(); chk_st("win_init", 4'd0, X_INIT);
        enter = 0;
        step(); chk_st("win_setup", 4'd1, X_SETUP);
        enter = 1;
        step(); chk_st("prep5", 4'd2, X_PREP);
        enter = 0;
        step(); chk_st("fpga5", 4'd3, X_FPGA);
        end_fpga = 1;
        step(); chk_st("user5", 4'd4, X_USER);
        end_fpga = 0; reset = 1;
        step(); chk_st("midgame_reset", 4'd0, X_INIT);
        reset = 0;
        step(); chk_st("midgame_setup", 4'd1, X_SETUP);
        force dut.state_q = state_t'(4'd12);
        #1;
        chk_st("illegal_code", 4'd12, X_IDLE);
        release dut.state_q;
        step(); chk_st("illegal_recover", 4'd0, X_INIT);
        step(); chk_st("illegal_setup", 4'd1, X_SETUP);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/game_control.md
# game_control

Control unit for the memory game: the command-side counterpart of the game datapath. It consumes the datapath status flags (end_fpga, end_user, end_time, win, match) and a player "enter" key, and drives the datapath command lines (r1, r2, e1–e4, sel). The block is a single Moore state machine with an internal rising-edge detector on the enter key. It sits beside the datapath in the top level, and both run on the same clock.

## Interface
- No parameters. State encoding is fixed in the shared package.
- Clocking: one clock; reset is synchronous and active-high.
- clock_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high; forces S_INIT.
- enter  in  1  enter key, already synchronized by ButtonSync, active-high level.
- end_fpga  in  1  FPGA sequence playback finished.
- end_user  in  1  user finished entering the current sequence.
- end_time  in  1  user input timeout.
- win  in  1  final round reached (round counter terminal count).
- match  in  1  user sequence equals FPGA sequence.
- r1  out  1  global reset: setup register and round counter.
- r2  out  1  per-round reset: time counter, FPGA counter, FPGA and user registers.
- e1  out  1  setup register load.
- e2  out  1  user phase enable.
- e3  out  1  FPGA playback enable.
- e4  out  1  round counter increment.
- sel  out  1  display select: 1 = game display, 0 = result message.
- state_o  out  4  current state code, for debug and verification.

## Operation
- Edge detection:
  - enter_q registers enter.
  - enter_p = enter & ~enter_q.
  - A held key yields exactly one enter_p pulse.
  - enter_q clears on reset.
- Moore outputs, decoded only from the state register. Defaults: all r/e outputs 0, sel = 1.
- States, with code, asserted outputs and next state:
  - S_INIT (0): r1 = 1, r2 = 1. Next: S_SETUP unconditionally.
  - S_SETUP (1): e1 = 1. Next: enter_p → S_PREP, else stay.
  - S_PREP (2): r2 = 1. Next: S_PLAY_FPGA.
  - S_PLAY_FPGA (3): e3 = 1. Next: end_fpga → S_PLAY_USER, else stay.
  - S_PLAY_USER (4): e2 = 1.
    - end_time → S_RESULT. This has priority over end_user in the same cycle.
    - Else end_user → S_CHECK.
    - Else stay.
  - S_CHECK (5): no enables. Next: match → S_NEXT, else S_RESULT.
  - S_NEXT (6): e4 = 1 for exactly one cycle. Next: S_ROUND_CHK.
  - S_ROUND_CHK (7): no enables. This state gives win one cycle to settle after the increment. Next: win → S_RESULT, else S_PREP.
  - S_RESULT (8): sel = 0. Next: enter_p → S_INIT, else stay.
- Unused codes 9–15 go to S_INIT on the next clock, with outputs at their defaults.
- enter_p is ignored in every state other than S_SETUP and S_RESULT.
- Status inputs are ignored outside the states listed above.

## Timing
- Reset values:
  - State is S_INIT, so state_o = 0.
  - r1 = 1, r2 = 1, sel = 1.
  - e1 = e2 = e3 = e4 = 0.
  - enter_q = 0.
- A reset asserted mid-game wins over every transition. On the next edge the block is in S_INIT, and r1/r2 pulse for one cycle after reset releases.
- Transition latency:
  - Output changes take effect in the cycle after the edge on which the input condition was sampled.
  - A key press reaches enter_p in the same cycle it rises, so the key-to-state change is one edge.
- Single-cycle pulses:
  - r1 for one cycle per S_INIT visit.
  - r2 for one cycle per S_PREP visit; S_INIT also pulses r2.
  - e4 for exactly one cycle per completed round.
- Level outputs:
  - e3 is held high for the whole playback.
  - e2 is held high for the whole user phase.
  - The datapath qualifies e2 with key activity itself.
- Minimum round loop: S_PREP → S_PLAY_FPGA → S_PLAY_USER → S_CHECK → S_NEXT → S_ROUND_CHK is 6 cycles when status flags are already high.

## Structure
- Package game_pkg holds:
  - The state_t enum (4-bit codes 0–8 as listed).
  - Localparams for the default output vector {r1, r2, e1, e2, e3, e4, sel} = 7'b0000001.
- Sub-module edge_detect: rising-edge detector with clock_50, reset, din and pulse ports. It is reusable for other key inputs.
- The top module contains the state register, the next-state logic and the output decode.

## Test plan
- Reset, then release. Required:
  - Cycle 0 after release: state_o = 0, r1 = r2 = 1, sel = 1.
  - Next cycle: state_o = 1, e1 = 1.
- Hold enter high for 100 cycles in S_SETUP. Required:
  - Exactly one transition, to S_PREP: r2 high for one cycle.
  - Then S_PLAY_FPGA with e3 = 1.
- Full round with match = 1, win = 0:
  - Sequence: end_fpga, then end_user.
  - Required path: states 3 → 4 → 5 → 6 → 7 → 2.
  - e4 pulses exactly once.
- end_time and end_user both high in S_PLAY_USER. Required: next state is 8, sel = 0, e4 never asserted.
- Mismatch and final round:
  - match = 0 in S_CHECK → state 8.
  - Separately, win = 1 in S_ROUND_CHK → state 8.
  - In both cases, enter in state 8 → state 0, then state 1.
- Reset in S_PLAY_USER mid-round, and a forced illegal code 12. Required in both cases: next state 0 with the reset output values.
